// File: rtl/if_pkg.sv
// Shared types and constants for the RV32I instruction-fetch stage.
package if_pkg;

   localparam int unsigned XLEN = 32;

   localparam logic [XLEN-1:0] IF_NOP_INSTR = 32'h0000_0013;
   localparam logic [XLEN-1:0] IF_RESET_PC  = 32'h0000_0000;

   typedef enum logic [1:0] {
      ST_REQ  = 2'd0,
      ST_WAIT = 2'd1,
      ST_HOLD = 2'd2
   } if_state_e;

   // Redirect targets are forced onto a word boundary
   function automatic logic [XLEN-1:0] word_align(input logic [XLEN-1:0] addr);
      return addr & ~XLEN'(3);
   endfunction

endpackage : if_pkg

// File: rtl/if_id_reg.sv
// IF/ID pipeline register: flush beats stall, stall holds, otherwise load or bubble.
module if_id_reg
   import if_pkg::*;
#(
   parameter logic [XLEN-1:0] NOP_INSTR = IF_NOP_INSTR
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            i_stall,
   input  logic            i_flush,
   input  logic            i_load,
   input  logic [XLEN-1:0] i_pc,
   input  logic [XLEN-1:0] i_instr,
   output logic [XLEN-1:0] o_pc,
   output logic [XLEN-1:0] o_pc_plus4,
   output logic [XLEN-1:0] o_instr,
   output logic            o_valid
);

   // PC fields only move on a real load; bubbles and flushes keep the last PC
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         o_pc       <= '0;
         o_pc_plus4 <= XLEN'(4);
         o_instr    <= NOP_INSTR;
         o_valid    <= 1'b0;
      end else if (i_flush) begin
         o_instr    <= NOP_INSTR;
         o_valid    <= 1'b0;
      end else if (!i_stall) begin
         if (i_load) begin
            o_pc       <= i_pc;
            o_pc_plus4 <= i_pc + XLEN'(4);
            o_instr    <= i_instr;
            o_valid    <= 1'b1;
         end else begin
            o_instr    <= NOP_INSTR;
            o_valid    <= 1'b0;
         end
      end
   end

endmodule : if_id_reg

// File: rtl/if_stage.sv
// RV32I fetch stage: PC, single-outstanding imem handshake, skid buffer, IF/ID register.
// Optional IF_PERF_CNT_EN adds fetch and kill performance counters.
module if_stage
   import if_pkg::*;
#(
   parameter logic [XLEN-1:0] RESET_PC  = IF_RESET_PC,
   parameter logic [XLEN-1:0] NOP_INSTR = IF_NOP_INSTR
) (
   input  logic            clk,
   input  logic            rst_n,
   output logic            imem_req,
   output logic [XLEN-1:0] imem_addr,
   input  logic            imem_gnt,
   input  logic            imem_rvalid,
   input  logic [XLEN-1:0] imem_rdata,
   input  logic            stall_D,
   input  logic            redirect_E,
   input  logic [XLEN-1:0] redirect_pc_E,
   output logic [XLEN-1:0] PC_D,
   output logic [XLEN-1:0] PCPlus4_D,
   output logic [XLEN-1:0] Instr_D,
   output logic            valid_D
`ifdef IF_PERF_CNT_EN
   ,
   output logic [XLEN-1:0] perf_fetch_cnt,
   output logic [XLEN-1:0] perf_kill_cnt
`endif
);

   if_state_e       r_state, w_state_n;
   logic [XLEN-1:0] r_pc, w_pc_n;
   logic [XLEN-1:0] r_fpc, w_fpc_n;
   logic [XLEN-1:0] r_skid_pc, w_skid_pc_n;
   logic [XLEN-1:0] r_skid_instr, w_skid_instr_n;
   logic            r_kill, w_kill_n;
   logic            r_req, w_req_n;
   logic            w_grant;
   logic            w_load;
   logic [XLEN-1:0] w_load_pc, w_load_instr;
   logic [XLEN-1:0] w_redir_pc;

   assign w_grant    = (r_state == ST_REQ) & r_req & imem_gnt;
   assign w_redir_pc = word_align(redirect_pc_E);

   assign imem_req  = r_req;
   assign imem_addr = r_pc;

   // State and fetch-side registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state      <= ST_REQ;
         r_pc         <= RESET_PC;
         r_fpc        <= '0;
         r_skid_pc    <= '0;
         r_skid_instr <= NOP_INSTR;
         r_kill       <= 1'b0;
         r_req        <= 1'b0;
      end else begin
         r_state      <= w_state_n;
         r_pc         <= w_pc_n;
         r_fpc        <= w_fpc_n;
         r_skid_pc    <= w_skid_pc_n;
         r_skid_instr <= w_skid_instr_n;
         r_kill       <= w_kill_n;
         r_req        <= w_req_n;
      end
   end

   // Next-state logic; a redirect always wins over stall and over a delivery
   always_comb begin
      w_state_n      = r_state;
      w_pc_n         = r_pc;
      w_fpc_n        = r_fpc;
      w_skid_pc_n    = r_skid_pc;
      w_skid_instr_n = r_skid_instr;
      w_kill_n       = r_kill;
      w_load         = 1'b0;
      w_load_pc      = r_fpc;
      w_load_instr   = imem_rdata;

      case (r_state)
         ST_REQ: begin
            if (w_grant) begin
               w_fpc_n   = r_pc;
               w_pc_n    = r_pc + XLEN'(4);
               w_state_n = ST_WAIT;
               w_kill_n  = redirect_E;
            end
         end
         ST_WAIT: begin
            if (imem_rvalid) begin
               if (redirect_E || r_kill) begin
                  w_kill_n  = 1'b0;
                  w_state_n = ST_REQ;
               end else if (stall_D) begin
                  w_skid_pc_n    = r_fpc;
                  w_skid_instr_n = imem_rdata;
                  w_state_n      = ST_HOLD;
               end else begin
                  w_load    = 1'b1;
                  w_state_n = ST_REQ;
               end
            end else if (redirect_E) begin
               w_kill_n = 1'b1;
            end
         end
         ST_HOLD: begin
            if (redirect_E) begin
               w_state_n = ST_REQ;
            end else if (!stall_D) begin
               w_load       = 1'b1;
               w_load_pc    = r_skid_pc;
               w_load_instr = r_skid_instr;
               w_state_n    = ST_REQ;
            end
         end
         default: begin
            w_state_n = ST_REQ;
            w_kill_n  = 1'b0;
         end
      endcase

      if (redirect_E) begin
         w_pc_n = w_redir_pc;
      end

      w_req_n = (w_state_n == ST_REQ);
   end

   if_id_reg #(
      .NOP_INSTR (NOP_INSTR)
   ) u_if_id_reg (
      .clk        (clk),
      .rst_n      (rst_n),
      .i_stall    (stall_D),
      .i_flush    (redirect_E),
      .i_load     (w_load),
      .i_pc       (w_load_pc),
      .i_instr    (w_load_instr),
      .o_pc       (PC_D),
      .o_pc_plus4 (PCPlus4_D),
      .o_instr    (Instr_D),
      .o_valid    (valid_D)
   );

`ifdef IF_PERF_CNT_EN
   logic            w_resp_drop;
   logic            w_skid_drop;
   logic            w_valid_flush;
   logic [XLEN-1:0] w_kill_inc;

   // A discarded skid entry counts as a dropped response
   assign w_resp_drop   = (r_state == ST_WAIT) & imem_rvalid & (r_kill | redirect_E);
   assign w_skid_drop   = (r_state == ST_HOLD) & redirect_E;
   assign w_valid_flush = redirect_E & valid_D;
   assign w_kill_inc    = XLEN'(w_resp_drop) + XLEN'(w_skid_drop) + XLEN'(w_valid_flush);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         perf_fetch_cnt <= '0;
         perf_kill_cnt  <= '0;
      end else begin
         if (w_load && !redirect_E && !stall_D) begin
            perf_fetch_cnt <= perf_fetch_cnt + XLEN'(1);
         end
         perf_kill_cnt <= perf_kill_cnt + w_kill_inc;
      end
   end
`endif

endmodule : if_stage

// File: tb/tb_if_stage.sv
// Directed bench for if_stage with a small one-outstanding instruction-memory responder.
module tb_if_stage;

   localparam logic [31:0] NOP = 32'h0000_0013;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_gnt;
   logic        imem_rvalid;
   logic [31:0] imem_rdata;
   logic        stall_D;
   logic        redirect_E;
   logic [31:0] redirect_pc_E;
   logic [31:0] PC_D;
   logic [31:0] PCPlus4_D;
   logic [31:0] Instr_D;
   logic        valid_D;
`ifdef IF_PERF_CNT_EN
   logic [31:0] perf_fetch_cnt;
   logic [31:0] perf_kill_cnt;
`endif

   int n_checks = 0;
   int n_pass   = 0;

   // Memory responder state and knobs
   logic        pending   = 1'b0;
   logic [31:0] paddr     = '0;
   logic        mem_delay = 1'b0;
   logic        gnt_off   = 1'b0;
   logic        spurious  = 1'b0;

   always #5 clk = ~clk;

   if_stage dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .imem_req      (imem_req),
      .imem_addr     (imem_addr),
      .imem_gnt      (imem_gnt),
      .imem_rvalid   (imem_rvalid),
      .imem_rdata    (imem_rdata),
      .stall_D       (stall_D),
      .redirect_E    (redirect_E),
      .redirect_pc_E (redirect_pc_E),
      .PC_D          (PC_D),
      .PCPlus4_D     (PCPlus4_D),
      .Instr_D       (Instr_D),
      .valid_D       (valid_D)
`ifdef IF_PERF_CNT_EN
      ,
      .perf_fetch_cnt (perf_fetch_cnt),
      .perf_kill_cnt  (perf_kill_cnt)
`endif
   );

   function automatic logic [31:0] instr_of(input logic [31:0] addr);
      if (addr == 32'h0) return 32'h0050_0093;
      return {addr[19:0], 12'h013};
   endfunction

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h", tag, got, exp);
   endtask

   task automatic step();
      @(negedge clk);
   endtask

   // Track grants/responses on the clock edge, drive responses mid-cycle
   always @(posedge clk) begin
      if (imem_rvalid) pending = 1'b0;
      if (imem_req && imem_gnt) begin
         pending = 1'b1;
         paddr   = imem_addr;
      end
   end

   always @(negedge clk) begin
      #2;
      imem_gnt    = !gnt_off;
      imem_rvalid = (pending && !mem_delay) || spurious;
      imem_rdata  = instr_of(paddr);
   end

   initial begin
      rst_n = 1'b0;
      imem_gnt = 1'b0; imem_rvalid = 1'b0; imem_rdata = '0;
      stall_D = 1'b0; redirect_E = 1'b0; redirect_pc_E = '0;
      step();
      check("rst_pc", PC_D, 32'h0);
      check("rst_pc4", PCPlus4_D, 32'h4);
      check("rst_instr", Instr_D, NOP);
      check("rst_valid", 32'(valid_D), 32'h0);
      check("rst_req", 32'(imem_req), 32'h0);
      step();
      rst_n = 1'b1;

      step();                                    // e1
      check("first_req", 32'(imem_req), 32'h1);
      check("first_addr", imem_addr, 32'h0);
      step(); step();                            // e2 grant, e3 deliver
      check("f0_pc", PC_D, 32'h0);
      check("f0_pc4", PCPlus4_D, 32'h4);
      check("f0_instr", Instr_D, 32'h0050_0093);
      check("f0_valid", 32'(valid_D), 32'h1);
      check("f0_next_addr", imem_addr, 32'h4);

      step(); step(); step();                    // e4..e6
      stall_D = 1'b1;
      step();                                    // e7 -> HOLD
      check("hold_req", 32'(imem_req), 32'h0);
      check("hold_pc", PC_D, 32'h4);
      step(); step();                            // e8, e9
      check("hold3_req", 32'(imem_req), 32'h0);
      check("hold3_pc", PC_D, 32'h4);
      check("hold3_valid", 32'(valid_D), 32'h0);
      stall_D = 1'b0;
      step();                                    // e10 skid -> IF/ID
      check("skid_pc", PC_D, 32'h8);
      check("skid_instr", Instr_D, instr_of(32'h8));
      check("skid_valid", 32'(valid_D), 32'h1);
      check("skid_next_addr", imem_addr, 32'hC);
      mem_delay = 1'b1;
      step();                                    // e11 grant 0xC
      redirect_E = 1'b1; redirect_pc_E = 32'h100;
      step();                                    // e12 redirect in WAIT
      check("redir_valid", 32'(valid_D), 32'h0);
      check("redir_instr", Instr_D, NOP);
      check("redir_req", 32'(imem_req), 32'h0);
      redirect_E = 1'b0; mem_delay = 1'b0;
      step();                                    // e13 killed response
      check("kill_valid", 32'(valid_D), 32'h0);
      check("kill_addr", imem_addr, 32'h100);
      check("kill_req", 32'(imem_req), 32'h1);

      step();                                    // e14 grant 0x100
      stall_D = 1'b1; redirect_E = 1'b1; redirect_pc_E = 32'h203;
      step();                                    // e15 redirect+rvalid+stall
      check("co_valid", 32'(valid_D), 32'h0);
      check("co_instr", Instr_D, NOP);
      check("co_addr", imem_addr, 32'h200);
      check("co_req", 32'(imem_req), 32'h1);
      stall_D = 1'b0; redirect_E = 1'b0;
      step(); step();                            // e16, e17
      check("tgt_pc", PC_D, 32'h200);
      check("tgt_pc4", PCPlus4_D, 32'h204);
      check("tgt_instr", Instr_D, instr_of(32'h200));
      gnt_off = 1'b1; redirect_E = 1'b1; redirect_pc_E = 32'hFFFF_FFFF;
      step();                                    // e18 redirect in REQ, no grant
      check("nogrant_addr", imem_addr, 32'hFFFF_FFFC);
      check("nogrant_valid", 32'(valid_D), 32'h0);
      redirect_E = 1'b0; gnt_off = 1'b0;
      step(); step();                            // e19, e20
      check("wrap_pc", PC_D, 32'hFFFF_FFFC);
      check("wrap_pc4", PCPlus4_D, 32'h0);
      check("wrap_instr", Instr_D, 32'hFFFF_C013);
      check("wrap_addr", imem_addr, 32'h0);

      stall_D = 1'b1;
      step(); step();                            // e21 grant, e22 -> HOLD
      check("hold2_valid", 32'(valid_D), 32'h1);
      check("hold2_req", 32'(imem_req), 32'h0);
      redirect_E = 1'b1; redirect_pc_E = 32'h40;
      step();                                    // e23 redirect in HOLD
      check("hflush_valid", 32'(valid_D), 32'h0);
      check("hflush_instr", Instr_D, NOP);
      check("hflush_addr", imem_addr, 32'h40);
      redirect_E = 1'b0; stall_D = 1'b0;
      step(); step();                            // e24, e25
      check("h40_pc", PC_D, 32'h40);
      check("h40_instr", Instr_D, instr_of(32'h40));
      gnt_off = 1'b1; spurious = 1'b1;
      step();                                    // e26 stray rvalid in REQ
      check("stray_valid", 32'(valid_D), 32'h0);
      check("stray_pc", PC_D, 32'h40);
      check("stray_addr", imem_addr, 32'h44);
      gnt_off = 1'b0; spurious = 1'b0;
      step(); step();                            // e27, e28
      check("f44_pc", PC_D, 32'h44);
      check("f44_valid", 32'(valid_D), 32'h1);
`ifdef IF_PERF_CNT_EN
      check("perf_fetch", perf_fetch_cnt, 32'd7);
      check("perf_kill", perf_kill_cnt, 32'd5);
`endif
      mem_delay = 1'b1;
      step();                                    // e29 grant 0x48, then reset
      rst_n = 1'b0;
      #1;
      check("mrst_pc", PC_D, 32'h0);
      check("mrst_pc4", PCPlus4_D, 32'h4);
      check("mrst_instr", Instr_D, NOP);
      check("mrst_valid", 32'(valid_D), 32'h0);
      check("mrst_addr", imem_addr, 32'h0);
`ifdef IF_PERF_CNT_EN
      check("mrst_perf", perf_fetch_cnt, 32'd0);
`endif
      step(); step();
      rst_n = 1'b1; mem_delay = 1'b0;
      step();                                    // late response ignored
      check("late_valid", 32'(valid_D), 32'h0);
      check("late_req", 32'(imem_req), 32'h1);
      check("late_addr", imem_addr, 32'h0);
      step(); step();
      check("re_pc", PC_D, 32'h0);
      check("re_instr", Instr_D, 32'h0050_0093);
      check("re_valid", 32'(valid_D), 32'h1);
`ifdef IF_PERF_CNT_EN
      check("re_perf", perf_fetch_cnt, 32'd1);
`endif

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule : tb_if_stage
